// File: rtl/com_uart_rcv.sv
// UART receiver for the COM peripheral.
// Oversamples the serial line on tick_os and recovers 5-8 data bits, LSB first.
// Checks optional odd/even parity and 1 or 2 stop bits.
// Each received byte is presented on a valid/ready holding register together with its error flags.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tick_os           oversample enable, one pulse per 1/OVERSAMPLE bit period
//   rx_port           serial line, asynchronous to clk
//   stop_bit_config   0 = 1 stop bit, 1 = 2 stop bits
//   parity_bit_config [1] parity enable, [0] 1 = odd, 0 = even
//   data_bit_config   data bits = 5 + value
//   data_bus_out_RX   held byte, zero-extended above the frame length
//   rx_valid/rx_ready holding-register handshake
//   parity_error      parity flag of the held byte
//   frame_error       stop-bit flag of the held byte
//   overrun_error     one-clk pulse when a completed frame is dropped
//   ctrl_idle_state   receiver FSM is idle
module com_uart_rcv #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter logic        START_BIT  = 1'b0,
  parameter logic        STOP_BIT   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_os,
  input  logic       rx_port,
  input  logic       stop_bit_config,
  input  logic [1:0] parity_bit_config,
  input  logic [1:0] data_bit_config,
  output logic [7:0] data_bus_out_RX,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun_error,
  output logic       ctrl_idle_state
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HalfTick = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LastTick = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } state_e;

  state_e        state_q, state_d;
  logic          sync_q, rxs_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          pe_q, pe_d;
  logic          fe_q, fe_d;
  logic          done_q, done_d;
  // Cleared after a frame ends on a line stuck at START_BIT, so a break does not retrigger.
  logic          armed_q, armed_d;
  logic          two_stop_q, two_stop_d;
  logic          par_en_q, par_en_d;
  logic          par_odd_q, par_odd_d;
  logic [1:0]    dbits_q, dbits_d;

  logic [7:0]    data_out_q, data_out_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  logic          bit_tick;
  logic [2:0]    last_bit;
  logic          stop_ok;

  assign bit_tick = (tick_cnt_q == LastTick);
  assign last_bit = 3'd4 + {1'b0, dbits_q};
  assign stop_ok  = (rxs_q == STOP_BIT);

  // Two-flop synchroniser for the asynchronous line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= STOP_BIT;
      rxs_q  <= STOP_BIT;
    end else begin
      sync_q <= rx_port;
      rxs_q  <= sync_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pe_d       = pe_q;
    fe_d       = fe_q;
    done_d     = 1'b0;
    armed_d    = armed_q;
    two_stop_d = two_stop_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    dbits_d    = dbits_q;

    if (tick_os) begin
      unique case (state_q)
        StIdle: begin
          if (!armed_q) begin
            armed_d = stop_ok;
          end else if (rxs_q == START_BIT) begin
            two_stop_d = stop_bit_config;
            par_en_d   = parity_bit_config[1];
            par_odd_d  = parity_bit_config[0];
            dbits_d    = data_bit_config;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
            pe_d       = 1'b0;
            fe_d       = 1'b0;
            state_d    = StStart;
          end
        end
        StStart: begin
          if (tick_cnt_q == HalfTick) begin
            tick_cnt_d = '0;
            state_d    = (rxs_q == START_BIT) ? StData : StIdle;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        StData: begin
          if (bit_tick) begin
            tick_cnt_d         = '0;
            shift_d[bit_cnt_q] = rxs_q;
            if (bit_cnt_q == last_bit) begin
              bit_cnt_d = '0;
              state_d   = par_en_q ? StParity : StStop1;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        StParity: begin
          if (bit_tick) begin
            tick_cnt_d = '0;
            // Unused upper shift bits are zero, so reducing all 8 bits is safe.
            pe_d       = rxs_q ^ (^shift_q) ^ par_odd_q;
            state_d    = StStop1;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        StStop1: begin
          if (bit_tick) begin
            tick_cnt_d = '0;
            fe_d       = !stop_ok;
            if (two_stop_q) begin
              state_d = StStop2;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
              armed_d = stop_ok;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        StStop2: begin
          if (bit_tick) begin
            tick_cnt_d = '0;
            fe_d       = fe_q | !stop_ok;
            state_d    = StIdle;
            done_d     = 1'b1;
            armed_d    = stop_ok;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Holding register: a completed frame loads only if the slot is free or being emptied now.
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = 1'b0;
    if (done_q) begin
      if (!valid_q || rx_ready) begin
        data_out_d = shift_q;
        perr_d     = pe_q;
        ferr_d     = fe_q;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      done_q     <= 1'b0;
      armed_q    <= 1'b1;
      two_stop_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      dbits_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      done_q     <= done_d;
      armed_q    <= armed_d;
      two_stop_q <= two_stop_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      dbits_q    <= dbits_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_bus_out_RX = data_out_q;
  assign rx_valid        = valid_q;
  assign parity_error    = perr_q;
  assign frame_error     = ferr_q;
  assign overrun_error   = ovr_q;
  assign ctrl_idle_state = (state_q == StIdle);

endmodule
